mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Sequencer and arbiter that shares one memory port between the core's instruction-fetch requester and its data-access requester, now that the data side is being brought up. It sits between the five-stage core and the unified instruction/data memory. It serialises single-word transactions with a request/valid handshake. Data is favoured on conflicts, with a starvation guard for fetch and a response timeout.

## Interface
- ADDR_WIDTH, 32, byte-address width of both requesters and of `mem_addr_o`.
- DATA_WIDTH, 32, word width.
- STARVE_LIMIT, 4, consecutive conflicting data grants before fetch is forced; 0 gives fetch priority on every conflict.
- TIMEOUT_CYCLES, 64, maximum ISSUE+WAIT cycles before abort; must be ≥2.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- inst_request_i  in  1  fetch request; held until `inst_valid_o`.
- inst_addr_i  in  ADDR_WIDTH  fetch byte address.
- inst_valid_o  out  1  one-cycle fetch completion.
- inst_rdata_o  out  DATA_WIDTH  fetched word.
- data_request_i  in  1  data request; held until `data_valid_o`.
- data_we_i  in  1  1 = store, 0 = load.
- data_addr_i  in  ADDR_WIDTH  data byte address.
- data_wdata_i  in  DATA_WIDTH  store data.
- data_valid_o  out  1  one-cycle data completion.
- data_rdata_o  out  DATA_WIDTH  load data.
- mem_request_o  out  1  one-cycle transaction strobe to memory.
- mem_we_o  out  1  write enable, held for the whole transaction.
- mem_addr_o  out  ADDR_WIDTH  word address = captured byte address >> 2, upper 2 bits 0.
- mem_wdata_o  out  DATA_WIDTH  write data, held for the whole transaction.
- mem_valid_i  in  1  memory completion.
- mem_rdata_i  in  DATA_WIDTH  memory read data, qualified by `mem_valid_i`.
- busy_o  out  1  state ≠ IDLE.
- timeout_o  out  1  one-cycle pulse, coincident with the aborted transaction's valid.

## Operation
- **FSM states.** IDLE, ISSUE, WAIT, RESP. Owner register `own` is 0 for inst and 1 for data.
- **IDLE arbitration:**
  - Only one request high: grant it.
  - Both high: grant inst if `starve_cnt >= STARVE_LIMIT`, otherwise grant data.
  - On grant, capture address, we and wdata into the mem_* registers, then go to ISSUE. Inst grants force we = 0 and wdata = 0.
- **Starvation counter.** `starve_cnt` increments, saturating at STARVE_LIMIT, on a data grant while `inst_request_i` is high. It clears to 0 on any inst grant.
- **ISSUE.** `mem_request_o` = 1 for exactly one cycle. If `mem_valid_i` is high, go to RESP; otherwise go to WAIT.
- **WAIT.** Stay until `mem_valid_i`, then go to RESP.
- **Timeout.** `to_cnt` counts cycles in ISSUE+WAIT. When it reaches TIMEOUT_CYCLES without `mem_valid_i`, go to RESP as an aborted transaction.
- **RESP:**
  - Assert the owner's valid_o for 1 cycle, then go to IDLE.
  - New requests are not sampled during RESP.
  - Read data is registered from `mem_rdata_i` at the completing edge.
  - `inst_rdata_o` and `data_rdata_o` update only on a completed read by their owner; stores leave `data_rdata_o` unchanged.
  - On timeout, the owner's rdata is set to 0 (for reads) and `timeout_o` = 1.
- `mem_valid_i` is ignored in IDLE and RESP, including a late response after a timeout.
- **Hold rule.** mem_addr_o, mem_we_o and mem_wdata_o hold from ISSUE through RESP. They change only at the next grant.

## Timing
- **Reset.** All outputs are 0, state = IDLE, `starve_cnt` = `to_cnt` = 0, both rdata = 0.
- **Reset mid-transaction.** Abort with no valid_o. A following `mem_valid_i` is ignored.
- **Minimum latency.** Request seen at edge T (IDLE) gives ISSUE in cycle T+1. `mem_valid_i` high in T+1 gives RESP/valid in T+2. The arbiter is back in IDLE at T+3.
- **Throughput.** At most one transaction per 3 cycles.
- **Requester drop.** A requester that drops its request before valid has its captured transaction completed anyway; valid still pulses.
- **Simultaneous events.** A request arriving in RESP waits for IDLE. If `mem_valid_i` and the timeout are reached in the same cycle, the valid wins and no timeout is flagged.

## Test plan
- **Single fetch.** `inst_request_i` = 1, addr 0x0000_0010. Expect `mem_request_o` one cycle later with `mem_addr_o` = 0x4 and `mem_we_o` = 0. Memory returns 0xDEADBEEF in the same cycle; 1 cycle later `inst_valid_o` = 1 and `inst_rdata_o` = 0xDEADBEEF.
- **Store then load.** Store to 0x20 with data 0x1234_5678: `mem_we_o` = 1, `mem_wdata_o` = 0x1234_5678, `data_rdata_o` unchanged. A load from 0x20 then returns 0x1234_5678 on `data_rdata_o`.
- **Conflict and starvation.** With STARVE_LIMIT = 2, hold inst and data requests high continuously. Grant order is data, data, inst, data, data, inst.
- **Variable latency.** Memory responds 5 cycles after ISSUE. Expect `busy_o` = 1 throughout, `mem_request_o` high for only 1 cycle, and exactly one valid_o.
- **Timeout.** With TIMEOUT_CYCLES = 8 and memory silent, expect `data_valid_o` = `timeout_o` = 1 in the same cycle and `data_rdata_o` = 0. A subsequent stray `mem_valid_i` produces no valid.
- **Async reset in WAIT.** Assert `rst` mid-cycle: outputs clear immediately. After release, the late `mem_valid_i` is ignored and a new fetch completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-word memory port between the instruction-fetch and
//   data-access requesters. One transaction at a time:
//   IDLE -> ISSUE -> (WAIT) -> RESP -> IDLE.
//   Data wins conflicts unless fetch has lost STARVE_LIMIT conflicts in a row.
//   A transaction that sees no memory response within TIMEOUT_CYCLES cycles
//   of ISSUE+WAIT is aborted.
//
// Ports
//   clk, rst             clock; asynchronous active-high reset
//   inst_request_i       fetch request, held until inst_valid_o
//   inst_addr_i          fetch byte address
//   inst_valid_o         one-cycle fetch completion
//   inst_rdata_o         last fetched word
//   data_request_i       data request, held until data_valid_o
//   data_we_i            1 = store, 0 = load
//   data_addr_i          data byte address
//   data_wdata_i         store data
//   data_valid_o         one-cycle data completion
//   data_rdata_o         last loaded word
//   mem_request_o        one-cycle strobe in ISSUE
//   mem_we_o             write enable, held from ISSUE through RESP
//   mem_addr_o           word address (byte address >> 2), held
//   mem_wdata_o          write data, held
//   mem_valid_i          memory completion (ISSUE/WAIT only)
//   mem_rdata_i          memory read data, qualified by mem_valid_i
//   busy_o               state != IDLE
//   timeout_o            pulses with the valid of an aborted transaction
module mem_port_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inst_request_i,
  input  logic [ADDR_WIDTH-1:0] inst_addr_i,
  output logic                  inst_valid_o,
  output logic [DATA_WIDTH-1:0] inst_rdata_o,
  input  logic                  data_request_i,
  input  logic                  data_we_i,
  input  logic [ADDR_WIDTH-1:0] data_addr_i,
  input  logic [DATA_WIDTH-1:0] data_wdata_i,
  output logic                  data_valid_o,
  output logic [DATA_WIDTH-1:0] data_rdata_o,
  output logic                  mem_request_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_valid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  busy_o,
  output logic                  timeout_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  // +2 keeps the counter at least one bit wide when STARVE_LIMIT is 0.
  localparam int SW = $clog2(STARVE_LIMIT + 2);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYCLES - 1);

  state_t                state_q, state_d;
  logic                  own_q, own_d;        // 0 = inst, 1 = data
  logic [SW-1:0]         starve_cnt_q, starve_cnt_d;
  logic [TW-1:0]         to_cnt_q, to_cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] inst_rdata_q, inst_rdata_d;
  logic [DATA_WIDTH-1:0] data_rdata_q, data_rdata_d;
  logic                  timeout_q, timeout_d;

  logic grant_inst, grant_data;

  // Data wins a conflict until fetch has been passed over STARVE_LIMIT times.
  always_comb begin
    grant_data = data_request_i && (!inst_request_i || (starve_cnt_q < STARVE_MAX));
    grant_inst = inst_request_i && !grant_data;
  end

  always_comb begin
    state_d      = state_q;
    own_d        = own_q;
    starve_cnt_d = starve_cnt_q;
    to_cnt_d     = to_cnt_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    timeout_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_inst || grant_data) begin
          state_d  = ISSUE;
          own_d    = grant_data;
          to_cnt_d = '0;
          if (grant_data) begin
            addr_d  = data_addr_i >> 2;
            we_d    = data_we_i;
            wdata_d = data_wdata_i;
            if (inst_request_i && (starve_cnt_q != STARVE_MAX))
              starve_cnt_d = starve_cnt_q + SW'(1);
          end else begin
            addr_d       = inst_addr_i >> 2;
            we_d         = 1'b0;
            wdata_d      = '0;
            starve_cnt_d = '0;
          end
        end
      end

      ISSUE, WAIT: begin
        // A response in the timeout cycle still counts as a completion.
        if (mem_valid_i) begin
          state_d = RESP;
          if (!we_q) begin
            if (own_q) data_rdata_d = mem_rdata_i;
            else       inst_rdata_d = mem_rdata_i;
          end
        end else if (to_cnt_q >= TO_LAST) begin
          state_d   = RESP;
          timeout_d = 1'b1;
          if (!we_q) begin
            if (own_q) data_rdata_d = '0;
            else       inst_rdata_d = '0;
          end
        end else begin
          state_d  = WAIT;
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end

      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      own_q        <= 1'b0;
      starve_cnt_q <= '0;
      to_cnt_q     <= '0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      own_q        <= own_d;
      starve_cnt_q <= starve_cnt_d;
      to_cnt_q     <= to_cnt_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
      timeout_q    <= timeout_d;
    end
  end

  assign mem_request_o = (state_q == ISSUE);
  assign busy_o        = (state_q != IDLE);
  assign inst_valid_o  = (state_q == RESP) && !own_q;
  assign data_valid_o  = (state_q == RESP) &&  own_q;
  assign timeout_o     = timeout_q;   // only ever set for the RESP cycle
  assign mem_addr_o    = addr_q;
  assign mem_we_o      = we_q;
  assign mem_wdata_o   = wdata_q;
  assign inst_rdata_o  = inst_rdata_q;
  assign data_rdata_o  = data_rdata_q;

endmodule
